// File: rtl/product_mem_pkg.sv
// Shared constants and types for the multiplier's product memory interface.
package product_mem_pkg;
    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 1 << LOGDEPTH;

    typedef logic [LOGDEPTH-1:0] mem_addr_t;
endpackage

// File: rtl/product_mem_array.sv
// Product storage: one write port and a registered read port with write-first bypass.
module product_mem_array
    import product_mem_pkg::*;
#(
    parameter int LOGDEPTH_P = LOGDEPTH,
    parameter int WIDTH_P    = WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  byp_en,
    input  logic [LOGDEPTH_P-1:0] wr_addr,
    input  logic [WIDTH_P-1:0]    wr_val,
    input  logic                  rd_en,
    input  logic [LOGDEPTH_P-1:0] rd_addr,
    input  logic                  rd_hit,
    output logic [WIDTH_P-1:0]    rd_val
);
    localparam int DEPTH_P = 1 << LOGDEPTH_P;

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic               bypass;

    // Bypass follows the raw write strobe so a clear-dropped write still answers the read.
    assign bypass = byp_en && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_val <= '0;
        end else if (rd_en) begin
            if (bypass) begin
                rd_val <= wr_val;
            end else if (rd_hit) begin
                rd_val <= mem[rd_addr];
            end else begin
                rd_val <= '0;
            end
        end
    end
endmodule

// File: rtl/product_mem.sv
// Product memory responder: valid tracking, consume-on-read, bulk clear and occupancy flags.
module product_mem
    import product_mem_pkg::*;
#(
    parameter int LOGDEPTH   = product_mem_pkg::LOGDEPTH,
    parameter int WIDTH      = product_mem_pkg::WIDTH,
    parameter int READ_CLEAR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN_writeMem,
    input  logic [LOGDEPTH-1:0] writeMem_addr,
    input  logic [WIDTH-1:0]    writeMem_val,
    input  logic                EN_readMem,
    input  logic [LOGDEPTH-1:0] readMem_addr,
    output logic [WIDTH-1:0]    readMem_val,
    output logic                VALID_readMem,
    output logic                ERR_readInvalid,
    input  logic                EN_clear,
    output logic [LOGDEPTH:0]   fill_count,
    output logic                FULL_mem,
    output logic                EMPTY_mem
);
    localparam int DEPTH_L = 1 << LOGDEPTH;

    logic [DEPTH_L-1:0] valid;
    logic               wr_en;
    logic               collide;
    logic               rd_hit;
    logic               wr_new;
    logic               consume;

    assign wr_en   = EN_writeMem && !EN_clear;
    assign collide = EN_writeMem && (writeMem_addr == readMem_addr);
    assign rd_hit  = collide || valid[readMem_addr];
    assign wr_new  = wr_en && !valid[writeMem_addr];
    // A same-address write keeps the entry alive, so no consume in that case.
    assign consume = (READ_CLEAR != 0) && EN_readMem && !EN_clear
                     && valid[readMem_addr] && !collide;

    product_mem_array #(
        .LOGDEPTH_P (LOGDEPTH),
        .WIDTH_P    (WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .byp_en  (EN_writeMem),
        .wr_addr (writeMem_addr),
        .wr_val  (writeMem_val),
        .rd_en   (EN_readMem),
        .rd_addr (readMem_addr),
        .rd_hit  (valid[readMem_addr]),
        .rd_val  (readMem_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VALID_readMem   <= 1'b0;
            ERR_readInvalid <= 1'b0;
        end else begin
            VALID_readMem   <= EN_readMem;
            ERR_readInvalid <= EN_readMem && !rd_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            fill_count <= '0;
        end else if (EN_clear) begin
            valid      <= '0;
            fill_count <= '0;
        end else begin
            if (consume) begin
                valid[readMem_addr] <= 1'b0;
            end
            if (wr_en) begin
                valid[writeMem_addr] <= 1'b1;
            end
            fill_count <= fill_count + (LOGDEPTH+1)'(wr_new) - (LOGDEPTH+1)'(consume);
        end
    end

    assign FULL_mem  = (fill_count == (LOGDEPTH+1)'(DEPTH_L));
    assign EMPTY_mem = (fill_count == '0);
endmodule

// File: tb/tb_product_mem.sv
// Bench for product_mem: non-destructive and consume-on-read instances against a set-based model.
module tb_product_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN_writeMem = 1'b0;
    logic [5:0]  writeMem_addr = '0;
    logic [31:0] writeMem_val = '0;
    logic        EN_readMem = 1'b0;
    logic [5:0]  readMem_addr = '0;
    logic        EN_clear = 1'b0;

    logic [31:0] rv [2];
    logic        vr [2];
    logic        er [2];
    logic [6:0]  fc [2];
    logic        fu [2];
    logic        em [2];
    logic [42:0] obs [2];
    logic [42:0] exp_v [2];

    // Model: memory contents, per-instance valid sets, last response data
    logic [31:0] m_mem [64];
    bit          m_valid [2][64];
    logic [31:0] m_last [2];

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    product_mem #(.READ_CLEAR(0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(rv[0]), .VALID_readMem(vr[0]), .ERR_readInvalid(er[0]),
        .EN_clear(EN_clear), .fill_count(fc[0]), .FULL_mem(fu[0]), .EMPTY_mem(em[0])
    );

    product_mem #(.READ_CLEAR(1)) dut_rc (
        .clk(clk), .rst_n(rst_n),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(rv[1]), .VALID_readMem(vr[1]), .ERR_readInvalid(er[1]),
        .EN_clear(EN_clear), .fill_count(fc[1]), .FULL_mem(fu[1]), .EMPTY_mem(em[1])
    );

    assign obs[0] = {rv[0], vr[0], er[0], fc[0], fu[0], em[0]};
    assign obs[1] = {rv[1], vr[1], er[1], fc[1], fu[1], em[1]};

    function automatic int popcount(input int d);
        int n = 0;
        for (int i = 0; i < 64; i++) n += m_valid[d][i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [42:0] pack_exp(input int d, input bit vld, input bit err);
        int cnt = popcount(d);
        return {m_last[d], vld, err, 7'(cnt), cnt == 64, cnt == 0};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) m_valid[d][i] = 1'b0;
            m_last[d] = '0;
            exp_v[d] = pack_exp(d, 1'b0, 1'b0);
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input bit we, input int wa, input logic [31:0] wv,
                         input bit re, input int ra, input bit clr);
        bit hitw, vld, err;
        EN_writeMem = we; writeMem_addr = wa[5:0]; writeMem_val = wv;
        EN_readMem = re; readMem_addr = ra[5:0]; EN_clear = clr;
        @(posedge clk);
        hitw = we && (wa == ra);
        for (int d = 0; d < 2; d++) begin
            vld = re;
            err = 1'b0;
            if (re) begin
                err = !(hitw || m_valid[d][ra]);
                m_last[d] = hitw ? wv : (m_valid[d][ra] ? m_mem[ra] : 32'h0);
            end
            if (clr) begin
                for (int i = 0; i < 64; i++) m_valid[d][i] = 1'b0;
            end else begin
                if (d == 1 && re && m_valid[d][ra] && !hitw) m_valid[d][ra] = 1'b0;
                if (we) m_valid[d][wa] = 1'b1;
            end
            exp_v[d] = pack_exp(d, vld, err);
        end
        if (we && !clr) m_mem[wa] = wv;
        #1;
        EN_writeMem = 1'b0; EN_readMem = 1'b0; EN_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || obs[d] !== {32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_read();
        cycle(0, 0, 0, 1, 5, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || rv[d] !== 32'h0 || vr[d] !== 1'b1 || er[d] !== 1'b1) begin
                n_err++;
                $display("FAIL invalid_read d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
    endtask

    task automatic test_fill_readback();
        for (int a = 0; a < 64; a++) begin
            cycle(1, a, a * 3, 0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v[d] || fu[d] !== (a == 63)) begin
                    n_err++;
                    $display("FAIL fill d%0d addr %0d: got %h want %h", d, a, obs[d], exp_v[d]);
                end
            end
        end
        for (int a = 0; a < 64; a++) begin
            cycle(0, 0, 0, 1, a, 0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v[d] || rv[d] !== 32'(a * 3) || er[d] !== 1'b0) begin
                    n_err++;
                    $display("FAIL readback d%0d addr %0d: got %h want %h", d, a, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_collision();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 10, 32'hDEADBEEF, 1, 10, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || rv[d] !== 32'hDEADBEEF || er[d] !== 1'b0 || fc[d] !== 7'd1) begin
                n_err++;
                $display("FAIL collision d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
    endtask

    task automatic test_consume();
        cycle(0, 0, 0, 0, 0, 1);
        for (int a = 0; a < 3; a++) cycle(1, a, $urandom, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        n_checks++;
        if (obs[1] !== exp_v[1] || fc[1] !== 7'd2 || fc[0] !== 7'd3) begin
            n_err++;
            $display("FAIL consume_count: got %h/%0d want %h/3", obs[1], fc[0], exp_v[1]);
        end
        cycle(0, 0, 0, 1, 1, 0);
        n_checks++;
        if (obs[1] !== exp_v[1] || er[1] !== 1'b1 || er[0] !== 1'b0) begin
            n_err++;
            $display("FAIL consume_reread: got err %b/%b want 0/1", er[0], er[1]);
        end
        cycle(1, 7, $urandom, 1, 2, 0);
        n_checks++;
        if (obs[1] !== exp_v[1] || fc[1] !== 7'd2 || obs[0] !== exp_v[0]) begin
            n_err++;
            $display("FAIL consume_write: got %h want %h", obs[1], exp_v[1]);
        end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        for (int a = 0; a < 64; a++) cycle(1, a, $urandom, 0, 0, 0);
        cycle(1, 4, 32'h1234_5678, 0, 0, 1);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || fc[d] !== 7'd0 || em[d] !== 1'b1) begin
                n_err++;
                $display("FAIL clear d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
        cycle(0, 0, 0, 1, 4, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || er[d] !== 1'b1) begin
                n_err++;
                $display("FAIL clear_read d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
        for (int a = 0; a < 64; a++) cycle(1, a, $urandom, 0, 0, 0);
        v = $urandom;
        cycle(1, 9, v, 1, 9, 1);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || rv[d] !== v || er[d] !== 1'b0 || fc[d] !== 7'd0) begin
                n_err++;
                $display("FAIL clear_bypass d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
    endtask

    task automatic test_random();
        int wa, ra;
        for (int i = 0; i < 500; i++) begin
            wa = $urandom_range(0, 63);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 63);
            cycle($urandom_range(0, 1), wa, $urandom, $urandom_range(0, 1), ra,
                  $urandom_range(0, 40) == 0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (obs[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL random d%0d cyc %0d: got %h want %h", d, i, obs[d], exp_v[d]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 8; a++) cycle(1, a, $urandom, 0, 0, 0);
        for (int a = 0; a < 3; a++) cycle(0, 0, 0, 1, a, 0);
        EN_readMem = 1'b1; readMem_addr = 6'd3;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || vr[d] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
        EN_readMem = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== exp_v[d] || vr[d] !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset d%0d: got %h want %h", d, obs[d], exp_v[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_read();
        test_fill_readback();
        test_collision();
        test_consume();
        test_clear();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/product_mem.md
Name: product_mem

Overview:
- Memory responder at the far end of the multiplier's write/read memory interface.
- Accepts EN_writeMem/writeMem_addr/writeMem_val product writes and serves EN_readMem/readMem_addr requests with a registered readMem_val one cycle later.
- Tracks per-entry valid bits and occupancy, and flags reads of unwritten entries.
- Supports a bulk clear and an optional consume-on-read mode, so the multiplier's fill/block-read cycle can repeat without stale data.

Parameters:
LOGDEPTH, 6, address width; DEPTH = 2**LOGDEPTH entries (64)
WIDTH, 32, data width of each entry
READ_CLEAR, 0, 1 = a valid read invalidates (consumes) the entry; 0 = reads are non-destructive

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
EN_writeMem  in  1  write strobe
writeMem_addr  in  LOGDEPTH  write address
writeMem_val  in  WIDTH  write data
EN_readMem  in  1  read strobe
readMem_addr  in  LOGDEPTH  read address
readMem_val  out  WIDTH  read data, registered, valid cycle after request
VALID_readMem  out  1  high the cycle readMem_val carries a response
ERR_readInvalid  out  1  high with VALID_readMem when the addressed entry was unwritten
EN_clear  in  1  invalidate all entries
fill_count  out  LOGDEPTH+1  number of valid entries, 0..DEPTH
FULL_mem  out  1  fill_count == DEPTH
EMPTY_mem  out  1  fill_count == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values: readMem_val=0, VALID_readMem=0, ERR_readInvalid=0, all valid bits=0, fill_count=0, EMPTY_mem=1, FULL_mem=0. Array contents are not reset.
- Reset asserted mid-operation: outputs go to reset values immediately. In-flight reads are dropped, with no VALID pulse after release.
- Write: with EN_writeMem at edge N, mem[addr]<=writeMem_val and valid[addr]<=1. Overwriting a valid entry is allowed and does not change the count.
- Read latency is 1 cycle. EN_readMem at edge N drives the following at edge N+1:
  - VALID_readMem=1 for exactly one cycle per request.
  - readMem_val = mem[addr] if valid, else 0.
  - ERR_readInvalid=1 iff the entry was invalid.
- With EN_readMem low: VALID_readMem=0 and readMem_val holds its last value. Back-to-back reads sustain one response per cycle.
- Read/write same address, same cycle: write-first. The response returns writeMem_val with ERR_readInvalid=0.
- READ_CLEAR=1 consume rules:
  - A valid (non-error) read clears valid[addr].
  - If a write targets the same address that cycle, the write wins and the entry stays valid.
- fill_count next value = current + (write to invalid entry) - (consume of valid entry).
  - Both events in one cycle on different addresses leave the count unchanged.
  - No wrap: the count never exceeds DEPTH or goes below 0.
- EN_clear has highest priority:
  - All valid bits go to 0 and fill_count goes to 0 at the edge.
  - A simultaneous write is dropped.
  - A simultaneous read is answered from pre-clear state (write-first bypass still applies to the data), and no consume is counted.
- FULL_mem and EMPTY_mem are decoded from the registered fill_count.
- Address wrap: addresses are modulo DEPTH by width, and all DEPTH entries are usable.

Decomposition:
- Shared package holds the LOGDEPTH and WIDTH defaults, the DEPTH constant, and a mem_addr_t typedef; the multiplier uses the same package.
- One sub-module, product_mem_array: storage, write port and registered read with write-first bypass.
- The top level holds the valid bits, consume/clear logic, counter and flags.

Test Plan:
- Reset then idle: rst_n low, then high -> fill_count=0, EMPTY_mem=1, VALID_readMem=0, readMem_val=0.
- Sequential fill and readback: write addr 0..63 with val=addr*3, then read addr 0..63 back-to-back.
  - During fill: FULL_mem=1 after the 64th write.
  - On readback: each VALID_readMem one cycle after its request, readMem_val=addr*3, ERR_readInvalid=0.
- Invalid read: read addr 5 after reset -> next cycle VALID_readMem=1, readMem_val=0, ERR_readInvalid=1.
- Collision: read and write addr 10 with val 0xDEADBEEF in the same cycle -> response 0xDEADBEEF, ERR_readInvalid=0, fill_count +1.
- READ_CLEAR=1 consume:
  - Fill 3 entries, read addr 1 -> fill_count 3->2; a second read of addr 1 gives ERR_readInvalid=1.
  - Write addr 7 while consume-reading addr 2 -> fill_count unchanged.
- Clear precedence and async reset:
  - Full memory, EN_clear with a write to addr 4 -> fill_count=0, EMPTY_mem=1; a later read of addr 4 gives ERR_readInvalid=1.
  - rst_n low mid-burst -> VALID_readMem drops to 0 immediately without waiting for an edge.
